// File: rtl/spi_flash_preamble_pkg.sv
// Shared flash constants for the preamble sequencer and the fill path.
package spi_flash_preamble_pkg;

    localparam logic [7:0] OP_RES       = 8'hAB;
    localparam logic [7:0] OP_RSTEN     = 8'h66;
    localparam logic [7:0] OP_RST       = 8'h99;
    localparam logic [7:0] OP_RDID      = 8'h9F;
    localparam logic [7:0] OP_READ_DUAL = 8'h3B;

    localparam logic [1:0] SCK_ON  = 2'b01;
    localparam logic [1:0] SCK_OFF = 2'b00;

    typedef enum logic [2:0] {
        StIdle, StGap, StCmd, StWait, StRx, StFlush, StDone
    } state_e;

    typedef enum logic [1:0] {
        OpRes, OpRstEn, OpRst, OpRdid
    } op_e;

    function automatic logic [7:0] op_byte(op_e op);
        logic [7:0] b;
        b = OP_RDID;
        unique case (op)
            OpRes:   b = OP_RES;
            OpRstEn: b = OP_RSTEN;
            OpRst:   b = OP_RST;
            OpRdid:  b = OP_RDID;
            default: b = OP_RDID;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_preamble_byte_tx.sv
// 8-bit MSB-first shifter; zeros shift in so the data bit idles low once a byte is out.
module spi_byte_tx (
    input  logic       clk2x,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       shift,
    output logic       bit_out,
    output logic       byte_tick
);

    logic [7:0] sh_q;
    logic [2:0] bit_cnt_q;

    always_ff @(posedge clk2x or negedge resetn) begin
        if (!resetn) begin
            sh_q      <= '0;
            bit_cnt_q <= '0;
        end else if (load) begin
            sh_q      <= data;
            bit_cnt_q <= '0;
        end else if (shift) begin
            sh_q      <= {sh_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end
    end

    assign bit_out   = sh_q[7];
    assign byte_tick = shift && (bit_cnt_q == 3'd7);

endmodule

// File: rtl/spi_flash_preamble.sv
// Flash bring-up sequencer: wake (0xAB), optional soft reset, JEDEC-ID read, then hand off pins.
module spi_flash_preamble
    import spi_flash_preamble_pkg::*;
#(
    parameter int unsigned T_RES   = 150,
    parameter int unsigned T_RST   = 1500,
    parameter int unsigned DO_RST  = 1,
    parameter int unsigned CS_GAP  = 4,
    parameter int unsigned RX_LAT  = 2,
    parameter logic [23:0] EXP_ID  = 24'hEF4016,
    parameter logic [23:0] ID_MASK = 24'hFF0000
) (
    input  logic        clk2x,
    input  logic        resetn,
    input  logic        i_start,
    output logic        o_own,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_id_ok,
    output logic [23:0] o_jedec_id,
    output logic        o_csb,
    output logic [1:0]  o_sck,
    output logic        o_mosi,
    output logic        o_mosi_oe,
    input  logic        i_miso
);

    localparam int unsigned TMax = (T_RES > T_RST) ? T_RES : T_RST;
    localparam int unsigned CntMax = (TMax > CS_GAP) ? TMax : CS_GAP;
    localparam int unsigned CW = $clog2(CntMax + 1);
    // Counters load N-1 and exit on zero, so a state lasts exactly N cycles.
    localparam logic [CW-1:0] GapLd   = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] ResLd   = CW'(T_RES - 1);
    localparam logic [CW-1:0] RstLd   = CW'(T_RST - 1);
    localparam logic [CW-1:0] FlushLd = CW'(RX_LAT - 1);

    state_e          state_q;
    op_e             op_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      rx_bytes_q;
    logic            start_q, start_prev_q;
    logic [RX_LAT-1:0] qual_q;
    logic [RX_LAT:0] qual_ext;
    logic [23:0]     id_shifted;
    logic            start_edge, tx_load, tx_shift, byte_tick;
    logic [7:0]      tx_data;

    assign start_edge = start_q & ~start_prev_q;
    assign tx_load    = (state_q == StGap) && (cnt_q == '0);
    assign tx_shift   = (state_q == StCmd) || (state_q == StRx);
    assign tx_data    = op_byte(op_q);
    assign qual_ext   = {qual_q, state_q == StRx};
    assign id_shifted = {o_jedec_id[22:0], i_miso};

    spi_byte_tx u_tx (
        .clk2x     (clk2x),
        .resetn    (resetn),
        .load      (tx_load),
        .data      (tx_data),
        .shift     (tx_shift),
        .bit_out   (o_mosi),
        .byte_tick (byte_tick)
    );

    always_ff @(posedge clk2x or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            op_q         <= OpRes;
            cnt_q        <= '0;
            rx_bytes_q   <= '0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            qual_q       <= '0;
            o_own        <= 1'b1;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_id_ok      <= 1'b0;
            o_jedec_id   <= '0;
            o_csb        <= 1'b1;
            o_sck        <= SCK_OFF;
            o_mosi_oe    <= 1'b0;
        end else begin
            start_q      <= i_start;
            start_prev_q <= start_q;
            // RX cycles delayed by the MISO return latency qualify each capture.
            qual_q       <= qual_ext[RX_LAT-1:0];
            if (qual_q[RX_LAT-1]) begin
                o_jedec_id <= id_shifted;
            end

            case (state_q)
                StIdle, StDone: begin
                    if (start_edge) begin
                        state_q    <= StGap;
                        cnt_q      <= GapLd;
                        op_q       <= OpRes;
                        o_own      <= 1'b1;
                        o_busy     <= 1'b1;
                        o_done     <= 1'b0;
                        o_id_ok    <= 1'b0;
                        o_jedec_id <= '0;
                    end
                end
                StGap: begin
                    if (cnt_q == '0) begin
                        state_q   <= StCmd;
                        o_csb     <= 1'b0;
                        o_sck     <= SCK_ON;
                        o_mosi_oe <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StCmd: begin
                    if (byte_tick) begin
                        o_mosi_oe <= 1'b0;
                        if (op_q == OpRdid) begin
                            state_q    <= StRx;
                            rx_bytes_q <= '0;
                        end else begin
                            o_csb <= 1'b1;
                            o_sck <= SCK_OFF;
                            unique case (op_q)
                                OpRes: begin
                                    state_q <= StWait;
                                    cnt_q   <= ResLd;
                                end
                                OpRstEn: begin
                                    state_q <= StGap;
                                    cnt_q   <= GapLd;
                                    op_q    <= OpRst;
                                end
                                default: begin
                                    state_q <= StWait;
                                    cnt_q   <= RstLd;
                                end
                            endcase
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StGap;
                        cnt_q   <= GapLd;
                        op_q    <= (op_q == OpRes && DO_RST != 0) ? OpRstEn : OpRdid;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StRx: begin
                    if (byte_tick) begin
                        rx_bytes_q <= rx_bytes_q + 2'd1;
                        if (rx_bytes_q == 2'd2) begin
                            state_q <= StFlush;
                            cnt_q   <= FlushLd;
                            o_csb   <= 1'b1;
                            o_sck   <= SCK_OFF;
                        end
                    end
                end
                StFlush: begin
                    if (cnt_q == '0) begin
                        // The final capture lands on this edge, so judge the shifted value.
                        state_q <= StDone;
                        o_own   <= 1'b0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        o_id_ok <= ((id_shifted ^ EXP_ID) & ID_MASK) == '0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_preamble.sv
// Directed bench: two sequencers (with and without soft reset) against a flash model.
module tb_spi_flash_preamble;

    localparam int G  = 4;
    localparam int TR = 150;
    localparam int TT = 1500;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] start = 2'b00;
    logic [1:0] miso = 2'b00;
    logic [1:0] own, busy, done, id_ok, csb, mosi, oe;
    logic [1:0] sck_a, sck_b;
    logic [23:0] id_a, id_b;

    spi_flash_preamble #(.DO_RST(1)) dut_a (
        .clk2x(clk), .resetn(resetn), .i_start(start[0]), .o_own(own[0]), .o_busy(busy[0]),
        .o_done(done[0]), .o_id_ok(id_ok[0]), .o_jedec_id(id_a), .o_csb(csb[0]),
        .o_sck(sck_a), .o_mosi(mosi[0]), .o_mosi_oe(oe[0]), .i_miso(miso[0])
    );

    spi_flash_preamble #(.DO_RST(0)) dut_b (
        .clk2x(clk), .resetn(resetn), .i_start(start[1]), .o_own(own[1]), .o_busy(busy[1]),
        .o_done(done[1]), .o_id_ok(id_ok[1]), .o_jedec_id(id_b), .o_csb(csb[1]),
        .o_sck(sck_b), .o_mosi(mosi[1]), .o_mosi_oe(oe[1]), .i_miso(miso[1])
    );

    typedef struct {
        logic [7:0] cmd;
        int         gap;
        int         len;
    } frame_t;

    frame_t      log_a[$];
    frame_t      log_b[$];
    logic [23:0] flash_id[2];
    int          fbits[2];
    logic [7:0]  fcmd[2];
    int          gap[2];
    int          gap_before[2];
    logic        in_frame[2];
    logic        d1[2];
    logic        d2[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            fbits[i] = 0; fcmd[i] = '0; gap[i] = 0; gap_before[i] = 0;
            in_frame[i] = 1'b0; d1[i] = 1'b0; d2[i] = 1'b0;
        end
    end

    // Flash model: one bit per cycle with CS low and SCK active; MISO returns 2 cycles later.
    always @(negedge clk) begin
        logic       fo;
        logic [1:0] sk;
        frame_t     f;
        for (int i = 0; i < 2; i++) begin
            fo = 1'b0;
            sk = (i == 0) ? sck_a : sck_b;
            if (csb[i]) begin
                if (in_frame[i]) begin
                    f.cmd = fcmd[i]; f.gap = gap_before[i]; f.len = fbits[i];
                    if (i == 0) log_a.push_back(f);
                    else log_b.push_back(f);
                    in_frame[i] = 1'b0;
                    gap[i] = 0;
                end
                gap[i]++;
            end else begin
                if (!in_frame[i]) begin
                    in_frame[i] = 1'b1; gap_before[i] = gap[i]; fbits[i] = 0; fcmd[i] = '0;
                end
                if (sk == 2'b01) begin
                    if (fbits[i] < 8) fcmd[i] = {fcmd[i][6:0], mosi[i]};
                    else if (fcmd[i] == 8'h9F && fbits[i] < 32) fo = flash_id[i][31 - fbits[i]];
                    fbits[i]++;
                end
            end
            miso[i] = d2[i];
            d2[i] = d1[i];
            d1[i] = fo;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    int          s_n;
    logic        s_own, s_done;
    logic [23:0] s_id;

    // Pulse start, optionally re-pulse at cycle re_at, count cycles until done rises.
    task automatic run_seq(int i, int re_at);
        int n;
        n = 0;
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk);
        while (1) begin
            @(negedge clk);
            start[i] = (n == re_at);
            if (n == 1) begin
                s_own = own[i]; s_done = done[i]; s_id = (i == 0) ? id_a : id_b;
            end
            if (n > 1 && done[i]) break;
            if (n > 5000) begin
                chk("seq_timeout", n, 0);
                break;
            end
            @(posedge clk);
            n++;
        end
        start[i] = 1'b0;
        s_n = n;
    endtask

    logic [7:0] exp_cmd[4];
    int         wn;

    initial begin
        exp_cmd[0] = 8'hAB; exp_cmd[1] = 8'h66; exp_cmd[2] = 8'h99; exp_cmd[3] = 8'h9F;
        flash_id[0] = 24'hEF4016;
        flash_id[1] = 24'hEF4016;
        repeat (3) @(negedge clk);
        chk("rst_own", own[0], 1);
        chk("rst_csb", csb[0], 1);
        chk("rst_sck", sck_a, 0);
        chk("rst_mosi", mosi[0], 0);
        chk("rst_oe", oe[0], 0);
        chk("rst_busy_done_ok", {busy[0], done[0], id_ok[0]}, 0);
        chk("rst_id", id_a, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Full sequence with soft reset; a start re-pulse while busy must be ignored.
        log_a.delete();
        run_seq(0, 300);
        chk("t1_cycles", s_n, 4 * G + 32 + TR + TT + 24 + 2 + 1);
        chk("t1_nframes", log_a.size(), 4);
        if (log_a.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("t1_cmd", log_a[k].cmd, exp_cmd[k]);
                chk("t1_len", log_a[k].len, (k == 3) ? 32 : 8);
            end
            chk("t1_gap_after_ab", log_a[1].gap >= TR, 1);
            chk("t1_gap_66_99", log_a[2].gap >= G, 1);
            chk("t1_gap_after_99", log_a[3].gap >= TT, 1);
        end
        chk("t2_id", id_a, 24'hEF4016);
        chk("t2_id_ok", id_ok[0], 1);
        chk("t2_done", done[0], 1);
        chk("t2_own", own[0], 0);
        chk("t2_busy", busy[0], 0);
        chk("t2_csb", csb[0], 1);
        chk("t2_sck", sck_a, 0);

        // Restart from DONE with a foreign manufacturer ID.
        flash_id[0] = 24'hC22016;
        log_a.delete();
        run_seq(0, -1);
        chk("t6_own_next", s_own, 1);
        chk("t6_done_clr", s_done, 0);
        chk("t6_id_clr", s_id, 0);
        chk("t3_cycles", s_n, 4 * G + 32 + TR + TT + 24 + 2 + 1);
        chk("t3_nframes", log_a.size(), 4);
        chk("t3_id", id_a, 24'hC22016);
        chk("t3_id_ok", id_ok[0], 0);
        chk("t3_done", done[0], 1);

        // No soft reset: only AB then 9F.
        log_b.delete();
        run_seq(1, -1);
        chk("t4_cycles", s_n, 2 * G + 8 + TR + 32 + 2 + 1);
        chk("t4_nframes", log_b.size(), 2);
        if (log_b.size() == 2) begin
            chk("t4_cmd0", log_b[0].cmd, 8'hAB);
            chk("t4_cmd1", log_b[1].cmd, 8'h9F);
            chk("t4_len1", log_b[1].len, 32);
            chk("t4_gap", log_b[1].gap >= TR, 1);
        end
        chk("t4_id", id_b, 24'hEF4016);
        chk("t4_id_ok", id_ok[1], 1);

        // Async reset during RX bit 10 of the ID read.
        flash_id[0] = 24'hEF4016;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wn = 0;
        while (wn < 4000) begin
            @(negedge clk);
            #1;
            if (in_frame[0] && fcmd[0] == 8'h9F && fbits[0] == 19) break;
            wn++;
        end
        chk("t5_reached_rx", wn < 4000, 1);
        resetn = 1'b0;
        #1;
        chk("t5_csb", csb[0], 1);
        chk("t5_sck", sck_a, 0);
        chk("t5_id", id_a, 0);
        chk("t5_own_busy", {own[0], busy[0]}, 2'b10);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        log_a.delete();
        run_seq(0, -1);
        chk("t5_nframes", log_a.size(), 4);
        chk("t5_id_after", id_a, 24'hEF4016);
        chk("t5_id_ok", id_ok[0], 1);
        chk("t5_done", done[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
